// File: rtl/seven_seg_scan.sv
// Time-multiplexed seven-segment driver: latches packed BCD/hex nibbles into shadow
// registers and scans them onto active-low cathodes and anodes one digit slot at a time.
module seven_seg_scan #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 100000,
   parameter bit HEX_EN      = 1'b0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load,
   input  logic                    blank_lz,
   input  logic                    enable,
   output logic [6:0]              seven_seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    scan_tick
);

   localparam int CW = $clog2(REFRESH_DIV);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
   localparam logic [6:0]    SEG_OFF  = 7'b1111111;

   // Slot timing and shadow state
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] val_q, val_d;
   logic [NUM_DIGITS-1:0]   dpsh_q, dpsh_d;

   // Registered pin drivers
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic                    tick_q, tick_d;

   // Currently selected digit
   logic [3:0]              nib_sel;
   logic                    dp_sel;
   logic                    blank_sel;
   logic [NUM_DIGITS-1:0]   an_sel;
   logic [NUM_DIGITS-1:0]   zero_above;
   logic                    zero_run;

   function automatic logic [6:0] decode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'b1000000;
         4'h1:    seg = 7'b1111001;
         4'h2:    seg = 7'b0100100;
         4'h3:    seg = 7'b0110000;
         4'h4:    seg = 7'b0011001;
         4'h5:    seg = 7'b0010010;
         4'h6:    seg = 7'b0000010;
         4'h7:    seg = 7'b1111000;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0010000;
         4'hA:    seg = HEX_EN ? 7'b0001000 : 7'b0111111;
         4'hB:    seg = HEX_EN ? 7'b0000011 : 7'b0111111;
         4'hC:    seg = HEX_EN ? 7'b1000110 : 7'b0111111;
         4'hD:    seg = HEX_EN ? 7'b0100001 : 7'b0111111;
         4'hE:    seg = HEX_EN ? 7'b0000110 : 7'b0111111;
         default: seg = HEX_EN ? 7'b0001110 : 7'b0111111;
      endcase
      return seg;
   endfunction

   // Refresh counter and digit index only move while the display is enabled.
   always_comb begin
      cnt_d  = cnt_q;
      idx_d  = idx_q;
      tick_d = 1'b0;
      if (enable) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
               idx_d  = '0;
               tick_d = 1'b1;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_comb begin
      val_d  = load ? value : val_q;
      dpsh_d = load ? dp_in : dpsh_q;
   end

   // zero_above[k] is set when nibble k and every more-significant nibble are zero.
   always_comb begin
      zero_run   = 1'b1;
      zero_above = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         zero_run      = zero_run & (val_q[4*k +: 4] == 4'h0);
         zero_above[k] = zero_run;
      end
   end

   always_comb begin
      nib_sel   = 4'h0;
      dp_sel    = 1'b0;
      blank_sel = 1'b0;
      an_sel    = '1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_q == IW'(k)) begin
            nib_sel   = val_q[4*k +: 4];
            dp_sel    = dpsh_q[k];
            blank_sel = blank_lz && (k != 0) && zero_above[k];
            an_sel[k] = 1'b0;
         end
      end
   end

   // Blanking only darkens the segments; the anode and decimal point still follow the slot.
   always_comb begin
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
      an_d  = '1;
      if (enable) begin
         seg_d = blank_sel ? SEG_OFF : decode(nib_sel);
         dp_d  = ~dp_sel;
         an_d  = an_sel;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         idx_q  <= '0;
         val_q  <= '0;
         dpsh_q <= '0;
         seg_q  <= SEG_OFF;
         dp_q   <= 1'b1;
         an_q   <= '1;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         idx_q  <= idx_d;
         val_q  <= val_d;
         dpsh_q <= dpsh_d;
         seg_q  <= seg_d;
         dp_q   <= dp_d;
         an_q   <= an_d;
         tick_q <= tick_d;
      end
   end

   assign seven_seg = seg_q;
   assign dp        = dp_q;
   assign an        = an_q;
   assign scan_tick = tick_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with a 4-digit display and 4-cycle slots;
// a second instance with hex decoding shares the same stimulus.
module tb_seven_seg_scan;

   localparam int ND = 4;
   localparam int RD = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        load;
   logic        blank_lz;
   logic        enable;
   logic [15:0] value;
   logic [3:0]  dp_in;

   logic [6:0]  seg, seg_h;
   logic        dp, dp_h;
   logic [3:0]  an, an_h;
   logic        tick, tick_h;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   seven_seg_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .HEX_EN(1'b0)) dut (
      .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .load(load),
      .blank_lz(blank_lz), .enable(enable), .seven_seg(seg), .dp(dp), .an(an),
      .scan_tick(tick)
   );

   seven_seg_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .HEX_EN(1'b1)) dut_hex (
      .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .load(load),
      .blank_lz(blank_lz), .enable(enable), .seven_seg(seg_h), .dp(dp_h), .an(an_h),
      .scan_tick(tick_h)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      load  = 1'b0;
      step();
      reset = 1'b0;
   endtask

   task automatic check_dark(input string tag);
      check({tag, "_an"},   32'(an),   32'h0000000F);
      check({tag, "_seg"},  32'(seg),  32'h0000007F);
      check({tag, "_dp"},   32'(dp),   32'h00000001);
      check({tag, "_tick"}, 32'(tick), 32'h00000000);
   endtask

   // Reset, load v on the first live edge, then check every cycle c = 2..last.
   // segs = {digit3, digit2, digit1, digit0}; dpn = expected active-low dp per digit.
   task automatic run_frame(input string tag, input logic [15:0] v, input logic [3:0] dpi,
                            input logic blz, input logic [27:0] segs,
                            input logic [3:0] dpn, input int last);
      int         d;
      logic [3:0] e_an;
      do_reset();
      enable   = 1'b1;
      load     = 1'b1;
      value    = v;
      dp_in    = dpi;
      blank_lz = blz;
      step();
      load = 1'b0;
      for (int c = 2; c <= last; c++) begin
         step();
         d    = ((c - 1) / 4) % 4;
         e_an = 4'hF;
         e_an[d] = 1'b0;
         check($sformatf("%s_an_c%0d", tag, c),   32'(an),   32'(e_an));
         check($sformatf("%s_seg_c%0d", tag, c),  32'(seg),  32'(segs[d*7 +: 7]));
         check($sformatf("%s_dp_c%0d", tag, c),   32'(dp),   32'(dpn[d]));
         check($sformatf("%s_tick_c%0d", tag, c), 32'(tick), 32'((c % 16) == 0));
      end
   endtask

   initial begin
      reset    = 1'b1;
      load     = 1'b0;
      blank_lz = 1'b0;
      enable   = 1'b0;
      value    = 16'h0000;
      dp_in    = 4'h0;
      step();
      step();
      check_dark("reset");

      // First live edge shows digit 0 of the cleared shadow
      reset  = 1'b0;
      enable = 1'b1;
      load   = 1'b1;
      value  = 16'h1234;
      step();
      load = 1'b0;
      check("first_an",  32'(an),  32'h0000000E);
      check("first_seg", 32'(seg), 32'h00000040);
      check("first_dp",  32'(dp),  32'h00000001);

      // 1234 scanned over 80 cycles; scan_tick every 16 cycles
      run_frame("h1234", 16'h1234, 4'b0000, 1'b0,
                {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1111, 81);

      run_frame("blz0070", 16'h0070, 4'b0000, 1'b1,
                {7'b1111111, 7'b1111111, 7'b1111000, 7'b1000000}, 4'b1111, 17);

      run_frame("blz0000", 16'h0000, 4'b0000, 1'b1,
                {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b1111, 17);

      run_frame("dash000A", 16'h000A, 4'b0001, 1'b0,
                {7'b1000000, 7'b1000000, 7'b1000000, 7'b0111111}, 4'b1110, 17);
      check("hexA_an",  32'(an_h),  32'h0000000E);
      check("hexA_seg", 32'(seg_h), 32'h00000008);

      // Freeze in the digit-2 slot at count 2, load while frozen, resume
      do_reset();
      blank_lz = 1'b0;
      dp_in    = 4'h0;
      enable   = 1'b1;
      load     = 1'b1;
      value    = 16'h1234;
      step();                                   // E1
      load = 1'b0;
      for (int c = 2; c <= 10; c++) step();     // E10: index 2, count 2
      enable = 1'b0;
      step();                                   // E11
      check_dark("frz_e11");
      step(); step(); step();                   // E14
      load  = 1'b1;
      value = 16'h5678;
      step();                                   // E15
      load = 1'b0;
      for (int c = 16; c <= 20; c++) step();    // E20
      check_dark("frz_e20");
      enable = 1'b1;
      step();                                   // E21
      check("res_e21_an",  32'(an),  32'h0000000B);
      check("res_e21_seg", 32'(seg), 32'h00000002);
      step();                                   // E22
      check("res_e22_an",  32'(an),  32'h0000000B);
      step();                                   // E23
      check("res_e23_an",  32'(an),  32'h00000007);
      check("res_e23_seg", 32'(seg), 32'h00000012);

      // Reset in the digit-3 slot together with a load: reset wins, shadows clear
      reset = 1'b1;
      load  = 1'b1;
      value = 16'h9999;
      step();
      check_dark("midrst");
      reset = 1'b0;
      load  = 1'b0;
      step();
      check("midrst_e1_an",  32'(an),  32'h0000000E);
      check("midrst_e1_seg", 32'(seg), 32'h00000040);
      check("midrst_e1_dp",  32'(dp),  32'h00000001);
      step(); step(); step();
      check("midrst_e4_an",  32'(an),  32'h0000000E);
      step();
      check("midrst_e5_an",  32'(an),  32'h0000000D);
      check("midrst_e5_seg", 32'(seg), 32'h00000040);

      // Load on the terminal-count edge: next digit shows the new contents
      do_reset();
      enable = 1'b1;
      load   = 1'b1;
      value  = 16'h1234;
      step();                                   // E1
      load = 1'b0;
      step(); step();                           // E3
      load  = 1'b1;
      value = 16'h0009;
      step();                                   // E4
      load = 1'b0;
      check("tcld_e4_an",  32'(an),  32'h0000000E);
      check("tcld_e4_seg", 32'(seg), 32'h00000019);
      step();                                   // E5
      check("tcld_e5_an",  32'(an),  32'h0000000D);
      check("tcld_e5_seg", 32'(seg), 32'h00000040);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 100000, clk cycles per digit slot; legal range >= 2.
REQ-003 Parameter HEX_EN, default 0; 1 = decode nibbles 10..15 as A..F, 0 = decimal-only.
REQ-004 Clocking and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 value  input  4*NUM_DIGITS  packed nibbles; nibble k (bits 4k+3:4k) is digit k; digit 0 = least significant.
REQ-008 dp_in  input  NUM_DIGITS  decimal point request per digit; 1 = point lit.
REQ-009 load  input  1  latch value and dp_in into shadow registers on this edge.
REQ-010 blank_lz  input  1  1 = blank leading zeros.
REQ-011 enable  input  1  0 = display dark, scan frozen.
REQ-012 seven_seg  output  7  cathodes {g,f,e,d,c,b,a}, bit 6 = g; active-low.
REQ-013 dp  output  1  decimal-point cathode, active-low.
REQ-014 an  output  NUM_DIGITS  anode selects, active-low, one-hot-low while enabled.
REQ-015 scan_tick  output  1  one-cycle high pulse at each frame wrap.

Function
REQ-016 Shadow value/dp registers SHALL update only on edges where load=1; the display SHALL use only shadow contents.
REQ-017 Refresh counter SHALL count 0..REFRESH_DIV-1 while enable=1; at terminal count it SHALL return to 0 and the digit index SHALL advance by one.
REQ-018 Digit index SHALL run 0..NUM_DIGITS-1 and wrap to 0; scan_tick SHALL be 1 for exactly the cycle after the edge on which the index wraps NUM_DIGITS-1 -> 0.
REQ-019 seven_seg, dp and an SHALL be registered, reflecting the index and shadow contents of the previous cycle (1-cycle latency; load-to-visible = 2 edges for the active digit).
REQ-020 an SHALL drive bit [index] low, all others high.
REQ-021 Decode 0..9 (gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-022 HEX_EN=1: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-023 HEX_EN=0: nibbles 10..15 SHALL display a dash, 0111111.
REQ-024 blank_lz=1: digit k>0 SHALL show 1111111 when its nibble and every more-significant nibble are 0; digit 0 SHALL never be blanked; anode still driven.
REQ-025 dp SHALL equal ~dp_shadow[index] and SHALL NOT be affected by blanking.
REQ-026 enable=0: next edge an=all 1s, seven_seg=1111111, dp=1, scan_tick=0; counter and index hold; enable 1 resumes the same digit at the held count.
REQ-027 load and terminal count on the same edge: both take effect; the newly selected digit displays the new shadow contents one edge later.
REQ-028 load while enable=0 SHALL still update shadows.

Reset
REQ-029 On an edge with reset=1: counter=0, index=0, shadows=0, an=all 1s, seven_seg=1111111, dp=1, scan_tick=0; overrides load and enable.
REQ-030 First edge after reset release with enable=1: an bit0 low, seven_seg=1000000, dp=1.
REQ-031 Reset asserted mid-frame SHALL produce the REQ-029 state on that edge, with no partial-slot carry-over.

Verification (NUM_DIGITS=4, REFRESH_DIV=4)
REQ-032 Reset, enable=1, load value=16'h1234 -> an=1110, seven_seg=0011001; 4 cycles later an=1101, seven_seg=0110000; then 0100100, 1111001.
REQ-033 Free run 64 cycles -> scan_tick pulses exactly every 16 cycles, each 1 cycle wide; an order 1110,1101,1011,0111.
REQ-034 blank_lz=1, value=16'h0070 -> digits 3,2 seven_seg=1111111 (an still low), digit 1=1111000, digit 0=1000000; value=16'h0000 -> only digit 0 lit, 1000000.
REQ-035 value=16'h000A, HEX_EN=0 -> digit 0 seven_seg=0111111; HEX_EN=1 -> 0001000; dp_in=4'b0001 -> dp=0 only in digit-0 slot.
REQ-036 enable=0 during digit-2 slot at count 2 -> an=1111, seven_seg=1111111; 10 cycles later enable=1 -> digit 2 resumes, advances after 2 more cycles.
REQ-037 reset pulsed during digit-3 slot with load=1 same cycle -> outputs match REQ-029; shadows=0.
